// File: rtl/text_pkg.sv
// Shared types and constants for the character text buffer controller:
// command and FSM encodings, buffer geometry and the fixed message table.
package text_pkg;

  localparam int MSG_LEN  = 32;
  localparam int ROW_W    = 3;
  localparam int COL_W    = 5;
  localparam int ADDR_W   = ROW_W + COL_W;
  localparam int NUM_MSGS = 4;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'b00,
    OP_CLR_ROW = 2'b01,
    OP_CLR_ALL = 2'b10,
    OP_NOP     = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_INIT_CLR,
    ST_IDLE,
    ST_LOAD,
    ST_CLR_ROW,
    ST_CLR_ALL,
    ST_DONE
  } state_e;

  // Each message is left-aligned ASCII, space-padded to a full row; column 0 is the top byte.
  localparam logic [MSG_LEN*8-1:0] MSG_TABLE [NUM_MSGS] = '{
    {"Ready",         {27{8'h20}}},
    {"Game over",     {23{8'h20}}},
    {"Player 1 wins", {19{8'h20}}},
    {"Player 2 wins", {19{8'h20}}}
  };

  function automatic logic [6:0] msg_char(input logic [1:0] idx, input logic [COL_W-1:0] col);
    return MSG_TABLE[idx][(MSG_LEN - 1 - int'(col)) * 8 +: 7];
  endfunction

endpackage

// File: rtl/text_buf_ram.sv
// Single-port character RAM with write enable and a registered, enabled read;
// storage is never reset so it maps onto block RAM, only the read register clears.
module text_buf_ram #(
  parameter int AW    = 8,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (en) begin
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/text_buf_ctrl.sv
// Text buffer controller: the display reads the buffer whenever it asks, and
// commands (load message, clear row, clear all) write only in the free slots.
module text_buf_ctrl #(
  parameter logic [6:0] CLR_CHAR = 7'h20,
  parameter int         MSG_LEN  = text_pkg::MSG_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       disp_en,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_msg,
  input  logic [2:0] cmd_row,
  output logic       busy,
  output logic       done
);

  import text_pkg::*;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(MSG_LEN - 1);

  state_e             state_reg;
  logic [ADDR_W-1:0]  cnt_reg;
  logic [ROW_W-1:0]   row_reg;
  logic [1:0]         msg_reg;
  logic               busy_reg;
  logic               ready_reg;
  logic               done_reg;

  logic               writing;
  logic               we;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  ram_addr;
  logic [6:0]         wdata;
  logic               last_col;
  logic               last_addr;

  assign writing = (state_reg == ST_INIT_CLR) || (state_reg == ST_LOAD) ||
                   (state_reg == ST_CLR_ROW)  || (state_reg == ST_CLR_ALL);
  // The display owns the port whenever it asks; writes only take the idle slots.
  assign we        = writing && !disp_en && !rst;
  assign last_col  = (cnt_reg[COL_W-1:0] == LAST_COL);
  assign last_addr = (cnt_reg == {ADDR_W{1'b1}});

  always_comb begin
    wr_addr = cnt_reg;
    wdata   = CLR_CHAR;
    if ((state_reg == ST_LOAD) || (state_reg == ST_CLR_ROW)) begin
      wr_addr = {row_reg, cnt_reg[COL_W-1:0]};
    end
    if (state_reg == ST_LOAD) begin
      wdata = msg_char(msg_reg, cnt_reg[COL_W-1:0]);
    end
  end

  // Display coordinates are {column,row}; the buffer is laid out row-major {row,column}.
  assign ram_addr = disp_en ? {char_xy[ROW_W-1:0], char_xy[7:ROW_W]} : wr_addr;

  text_buf_ram #(
    .AW    (ADDR_W),
    .WIDTH (7)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (disp_en),
    .we    (we),
    .addr  (ram_addr),
    .wdata (wdata),
    .rdata (char_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_INIT_CLR;
      cnt_reg   <= '0;
      row_reg   <= '0;
      msg_reg   <= '0;
      busy_reg  <= 1'b1;
      ready_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_INIT_CLR: begin
          if (!disp_en) begin
            if (last_addr) begin
              state_reg <= ST_IDLE;
              cnt_reg   <= '0;
              busy_reg  <= 1'b0;
              ready_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end

        ST_IDLE: begin
          if (cmd_valid && ready_reg) begin
            row_reg   <= cmd_row;
            msg_reg   <= cmd_msg;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            ready_reg <= 1'b0;
            case (cmd_op_e'(cmd_op))
              OP_LOAD:    state_reg <= ST_LOAD;
              OP_CLR_ROW: state_reg <= ST_CLR_ROW;
              OP_CLR_ALL: state_reg <= ST_CLR_ALL;
              default: begin
                state_reg <= ST_DONE;
                done_reg  <= 1'b1;
              end
            endcase
          end
        end

        ST_LOAD, ST_CLR_ROW: begin
          if (!disp_en) begin
            if (last_col) begin
              state_reg <= ST_DONE;
              cnt_reg   <= '0;
              done_reg  <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end

        ST_CLR_ALL: begin
          if (!disp_en) begin
            if (last_addr) begin
              state_reg <= ST_DONE;
              cnt_reg   <= '0;
              done_reg  <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end

        default: begin
          state_reg <= ST_INIT_CLR;
          cnt_reg   <= '0;
          busy_reg  <= 1'b1;
          ready_reg <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = ready_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule
